ad_bus_mem_responder: RTL

- Memory-side responder for the CPU's 16-bit multiplexed address/data bus. It is the far end of the bus interface unit that fills the 6-byte prefetch queue and performs operand accesses.
- Latches the address on ALE, decodes byte lanes from A0/BHE_n, inserts programmable wait states through READY, and services reads by driving AD and writes by capturing AD.
- Holds a local word-organised memory window, used as the boot/instruction memory model and as the bench target for the CPU core.

---
 rtl/cisc_bus_pkg.sv | 39 +++
 rtl/bus_mem_array.sv | 24 ++
 rtl/ad_bus_mem_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cisc_bus_pkg.sv
// Shared definitions for the multiplexed AD bus memory responder.
package cisc_bus_pkg;

  localparam int unsigned AD_W = 16;
  localparam int unsigned ST_W = 3;

  // Bus FSM state encodings
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_ADDR = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT = 3'd2;
  localparam logic [ST_W-1:0] ST_RD   = 3'd3;
  localparam logic [ST_W-1:0] ST_WR   = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE = 3'd5;

  // Lane codes as {bhe_n, A0}
  localparam logic [1:0] LANE_WORD = 2'b00;
  localparam logic [1:0] LANE_EVEN = 2'b10;
  localparam logic [1:0] LANE_ODD  = 2'b01;
  localparam logic [1:0] LANE_NONE = 2'b11;

  // Byte enables {hi, lo} for a lane code
  function automatic logic [1:0] lane_be(input logic [1:0] lane);
    logic [1:0] be;
    be = 2'b00;
    case (lane)
      LANE_WORD: be = 2'b11;
      LANE_EVEN: be = 2'b01;
      LANE_ODD:  be = 2'b10;
      default:   be = 2'b00;
    endcase
    return be;
  endfunction

  // Expand byte enables to a 16-bit data mask
  function automatic logic [AD_W-1:0] be_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Word-organised storage with byte write enables and combinational read.
module bus_mem_array
  import cisc_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic [1:0]               we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [AD_W-1:0]          wdata_i,
  output logic [AD_W-1:0]          rdata_o
);

  logic [AD_W-1:0] mem_q [DEPTH];

  // Byte-lane write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ad_bus_mem_responder.sv
// Memory-side responder for the 16-bit multiplexed AD bus.
module ad_bus_mem_responder
  import cisc_bus_pkg::*;
#(
  parameter int unsigned    DEPTH       = 256,
  parameter logic [15:0]    BASE_ADDR   = 16'h0000,
  parameter int unsigned    WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  input  logic        ale,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        bhe_n,
  output logic        ready,
  output logic        sel,
  output logic        err
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam logic [16:0] SPAN = 17'(2 * DEPTH);

  logic [ST_W-1:0] state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic            bhe_q, bhe_d;
  logic            is_wr_q, is_wr_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [15:0]     ad_out_q, ad_out_d;
  logic            ad_oe_q, ad_oe_d;
  logic            ready_q, ready_d;
  logic            sel_q, sel_d;
  logic            err_q, err_d;

  logic [16:0]     in_off_c;
  logic            hit_c;
  logic [15:0]     off_c;
  logic [IW-1:0]   idx_c;
  logic [1:0]      be_c;
  logic [1:0]      we_c;
  logic [15:0]     rdata_c;
  logic            strobe_low_c;
  logic            unused_c;

  // Window hit for the address currently on the bus
  assign in_off_c = {1'b0, ad_in} - {1'b0, BASE_ADDR};
  assign hit_c    = !in_off_c[16] && (in_off_c < SPAN);

  // Word index and byte lanes from the latched address
  assign off_c    = addr_q - BASE_ADDR;
  assign idx_c    = off_c[IW:1];
  assign be_c     = lane_be({bhe_q, addr_q[0]});
  assign unused_c = ^off_c;

  bus_mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (we_c),
    .addr_i  (idx_c),
    .wdata_i (ad_in),
    .rdata_o (rdata_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      bhe_q    <= 1'b0;
      is_wr_q  <= 1'b0;
      wcnt_q   <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      ready_q  <= 1'b1;
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bhe_q    <= bhe_d;
      is_wr_q  <= is_wr_d;
      wcnt_q   <= wcnt_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      ready_q  <= ready_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
    end
  end

  // Next-state, write strobe and next-output decode
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bhe_d        = bhe_q;
    is_wr_d      = is_wr_q;
    wcnt_d       = wcnt_q;
    sel_d        = sel_q;
    err_d        = 1'b0;
    we_c         = 2'b00;
    strobe_low_c = is_wr_q ? !wr_n : !rd_n;

    case (state_q)
      ST_IDLE: begin
        if (ale) begin
          addr_d  = ad_in;
          bhe_d   = bhe_n;
          sel_d   = hit_c;
          state_d = hit_c ? ST_ADDR : ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ale) begin
          addr_d  = ad_in;
          bhe_d   = bhe_n;
          sel_d   = hit_c;
          state_d = hit_c ? ST_ADDR : ST_IDLE;
        end else if (!rd_n && !wr_n) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!rd_n || !wr_n) begin
          is_wr_d = !wr_n;
          if (WAIT_STATES > 0) begin
            wcnt_d  = 4'(WAIT_STATES - 1);
            state_d = ST_WAIT;
          end else begin
            state_d = !wr_n ? ST_WR : ST_RD;
          end
        end
      end
      ST_WAIT: begin
        if (!strobe_low_c) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = is_wr_q ? ST_WR : ST_RD;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_RD: begin
        if (rd_n) state_d = ST_IDLE;
      end
      ST_WR: begin
        // Single write per access; DONE absorbs a long-held strobe
        if (!wr_n) begin
          we_c    = be_c & {2{rst_n}};
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (wr_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs registered from the next state so they align with it
    ready_d  = (state_d != ST_WAIT);
    ad_oe_d  = (state_d == ST_RD);
    ad_out_d = (state_d == ST_RD) ? (rdata_c & be_mask(be_c)) : 16'h0000;
  end

  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign ready  = ready_q;
  assign sel    = sel_q;
  assign err    = err_q;

endmodule
